// File: rtl/mul_5x3_assign_if.sv
// mul_5x3_assign_if: operand/result bundle for the dual signed 5x3 multiplier
// master drives operands and reads products; slave is the multiplier side
interface mul_5x3_assign_if #(
    parameter int A_W = 5,
    parameter int B_W = 3,
    parameter int P_W = A_W + B_W
);
    logic                  in_valid;
    logic signed [A_W-1:0] a;
    logic signed [B_W-1:0] b;
    logic signed [A_W-1:0] c;
    logic signed [B_W-1:0] d;
    logic signed [P_W-1:0] s1;
    logic signed [P_W-1:0] s2;
    logic                  out_valid;

    modport master (output in_valid, a, b, c, d, input s1, s2, out_valid);
    modport slave  (input in_valid, a, b, c, d, output s1, s2, out_valid);
endinterface

// File: rtl/mul_5x3_assign.sv
// mul_5x3_assign: two independent signed 5x3 shift-add multiplier lanes, registered products
// MUL_5X3_PIPE2_EN registers the row sums too, giving latency 2 instead of 1
module mul_5x3_assign #(
    parameter  int A_W = 5,
    parameter  int B_W = 3,
    localparam int P_W = A_W + B_W
) (
    input logic clk,
    input logic rst_n,
    mul_5x3_assign_if.slave bus
);
    logic [A_W-1:0] mcand [2];
    logic [B_W-1:0] mplr  [2];
    logic [P_W-1:0] rows  [2][B_W];
    logic [P_W-1:0] acc   [2][B_W-1];
    logic [P_W-1:0] pos   [2];
    logic [P_W-1:0] neg   [2];
    logic [P_W-1:0] fin   [2];
    logic           fin_v;

    assign mcand[0] = bus.a;
    assign mcand[1] = bus.c;
    assign mplr[0]  = bus.b;
    assign mplr[1]  = bus.d;

    genvar l, j;
    generate
        for (l = 0; l < 2; l++) begin : g_lane
            for (j = 0; j < B_W; j++) begin : g_row
                assign rows[l][j] = mplr[l][j] ? {{(P_W-A_W){mcand[l][A_W-1]}}, mcand[l]} << j : '0;
            end
            assign acc[l][0] = rows[l][0];
            for (j = 1; j < B_W-1; j++) begin : g_acc
                assign acc[l][j] = acc[l][j-1] + rows[l][j];
            end
            // multiplier MSB carries weight -2^(B_W-1), so its row is subtracted
            assign pos[l] = acc[l][B_W-2];
            assign neg[l] = rows[l][B_W-1];
        end
    endgenerate

`ifdef MUL_5X3_PIPE2_EN
    logic [P_W-1:0] pos_q [2];
    logic [P_W-1:0] neg_q [2];
    logic           v1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1 <= 1'b0;
            for (int i = 0; i < 2; i++) begin
                pos_q[i] <= '0;
                neg_q[i] <= '0;
            end
        end else begin
            v1 <= bus.in_valid;
            if (bus.in_valid) begin
                pos_q <= pos;
                neg_q <= neg;
            end
        end
    end

    assign fin[0] = pos_q[0] - neg_q[0];
    assign fin[1] = pos_q[1] - neg_q[1];
    assign fin_v  = v1;
`else
    assign fin[0] = pos[0] - neg[0];
    assign fin[1] = pos[1] - neg[1];
    assign fin_v  = bus.in_valid;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.s1        <= '0;
            bus.s2        <= '0;
            bus.out_valid <= 1'b0;
        end else begin
            bus.out_valid <= fin_v;
            if (fin_v) begin
                bus.s1 <= fin[0];
                bus.s2 <= fin[1];
            end
        end
    end
endmodule

// File: tb/tb_mul_5x3_assign.sv
// tb_mul_5x3_assign: directed and exhaustive checks of the dual signed 5x3 multiplier
// honours MUL_5X3_PIPE2_EN by expecting latency 2
module tb_mul_5x3_assign;
`ifdef MUL_5X3_PIPE2_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int checks = 0;
    int errors = 0;
    int q1[$], q2[$];

    mul_5x3_assign_if bus ();
    mul_5x3_assign dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic drive(input logic v, input int ai, input int bi, input int ci, input int di);
        bus.in_valid = v;
        bus.a = 5'(ai);
        bus.b = 3'(bi);
        bus.c = 5'(ci);
        bus.d = 3'(di);
    endtask

    task automatic single(input int ai, input int bi, input int ci, input int di, input int e1, input int e2);
        drive(1'b1, ai, bi, ci, di);
        repeat (LAT) begin
            @(posedge clk);
            #1;
            bus.in_valid = 1'b0;
        end
        check("corner_s1", int'(bus.s1), e1);
        check("corner_s2", int'(bus.s2), e2);
        check("corner_v", int'(bus.out_valid), 1);
    endtask

    int corners [4][6] = '{
        '{-16, -4,  15, -4,  64, -60},
        '{-16,  3,   7,  0, -48,   0},
        '{  0, -4,  -1, -1,   0,   1},
        '{-16, -1,  -5,  3,  16, -15}
    };

    initial begin
        drive(1'b1, 9, -3, -11, 2);
        repeat (3) begin
            @(posedge clk);
            #1;
            check("rst_s1", int'(bus.s1), 0);
            check("rst_s2", int'(bus.s2), 0);
            check("rst_v", int'(bus.out_valid), 0);
        end
        rst_n = 1'b1;
        for (int i = 0; i < 256; i++) begin
            int ai, bi, ci, di;
            ai = i / 8 - 16;
            bi = i % 8 - 4;
            ci = (i / 8 + 7) % 32 - 16;
            di = (i + 5) % 8 - 4;
            drive(1'b1, ai, bi, ci, di);
            q1.push_back(ai * bi);
            q2.push_back(ci * di);
            @(posedge clk);
            #1;
            if (q1.size() == LAT) begin
                check("exh_s1", int'(bus.s1), q1.pop_front());
                check("exh_s2", int'(bus.s2), q2.pop_front());
                check("exh_v", int'(bus.out_valid), 1);
            end
        end
        bus.in_valid = 1'b0;
        while (q1.size() > 0) begin
            @(posedge clk);
            #1;
            check("flush_s1", int'(bus.s1), q1.pop_front());
            check("flush_s2", int'(bus.s2), q2.pop_front());
        end
        foreach (corners[k])
            single(corners[k][0], corners[k][1], corners[k][2], corners[k][3], corners[k][4], corners[k][5]);
        repeat (2) @(posedge clk);
        #1;
        drive(1'b1, 5, -3, 0, 0);
        for (int t = 1; t <= 4; t++) begin
            @(posedge clk);
            #1;
            bus.in_valid = 1'b0;
            check("pulse_v", int'(bus.out_valid), int'(t == LAT));
            if (t >= LAT) check("pulse_s1", int'(bus.s1), -15);
        end
        drive(1'b1, 3, 3, -2, -3);
        repeat (2) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("midrst_s1", int'(bus.s1), 0);
        check("midrst_s2", int'(bus.s2), 0);
        check("midrst_v", int'(bus.out_valid), 0);
        @(posedge clk);
        #3;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        drive(1'b1, 0, 0, -7, 2);
        for (int t = 1; t <= LAT; t++) begin
            @(posedge clk);
            #1;
            bus.in_valid = 1'b0;
            check("post_v", int'(bus.out_valid), int'(t == LAT));
        end
        check("post_s2", int'(bus.s2), -14);
        check("post_s1", int'(bus.s1), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
